// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//
// Definitions shared by the sequential 3-to-8 decoder and its code FIFO.
//
// Contents:
//   CODE_W / DATA_W   - widths of the binary code and the one-hot word
//   ST_IDLE/ST_DRIVE/ST_GAP
//                     - FSM state encodings for the pulse generator
//   onehot8(code)     - maps a 3-bit binary index to an 8-bit one-hot word
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int CODE_W = 3;
    localparam int DATA_W = 8;

    // Plain constants rather than an enum so the encoding stays stable for any
    // downstream logic or netlist tooling that expects fixed state values.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Bit 'code' of the returned word is set and every other bit is clear.
    function automatic logic [DATA_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder_pulse_code_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
//
// Small synchronous FIFO that buffers 3-bit codes between the valid/ready
// input handshake and the pulse-generating FSM.
//
// Parameters:
//   DEPTH      - number of entries, power of two in 2..16
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset; empties the FIFO
//   push       - write push_code this cycle (ignored while full)
//   push_code  - code to write
//   pop        - retire the head entry this cycle (ignored while empty)
//   pop_code   - head entry, valid whenever empty is low
//   full       - count has reached DEPTH
//   empty      - count is zero
//   count      - number of stored entries, 0..DEPTH
//
// Push and pop on the same edge both take effect and leave count unchanged.
// Status outputs come from the registered count only, so a pop in the same
// cycle never makes a full FIFO look writable.
// -----------------------------------------------------------------------------
module code_fifo
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [CODE_W-1:0]        push_code,
    input  logic                     pop,
    output logic [CODE_W-1:0]        pop_code,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    // NOTE: the storage array has no reset; only the pointers and the count
    // define which entries are meaningful, and leaving the array unreset lets
    // it map onto plain registers or distributed RAM without a reset network.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_code;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge value of its neighbours regardless of the
    // order in which the simulator evaluates the processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits wide, so they wrap back to
            // entry 0 on their own when they pass the last entry.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_code = mem[rd_ptr];
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/decoder_pulse.sv
// -----------------------------------------------------------------------------
// decoder_pulse
//
// Sequential 3-to-8 one-hot decoder. Binary codes are accepted over a
// valid/ready handshake, buffered in code_fifo, and each one is replayed on
// Data as a one-hot word held for HOLD cycles, followed by GAP cycles of zero.
// Data is suitable for feeding the 8-to-3 priority encoder or any one-hot
// select consumer.
//
// Parameters:
//   HOLD       - cycles each one-hot word is driven, 1..255
//   GAP        - cycles Data is forced to zero between words, 0..255;
//                0 chains queued words back to back with no zero cycle
//   DEPTH      - FIFO entries, power of two in 2..16
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset; flushes queued codes
//   Code       - binary index to decode (bit Code of Data is set)
//   Code_valid - Code is valid this cycle
//   Code_ready - FIFO can accept; transfer when Code_valid && Code_ready
//   Data       - registered one-hot word, or 8'h00 when not driving
//   Busy       - FSM not idle or FIFO not empty
//   Done       - registered one-cycle pulse in the last drive cycle of a word
//
// Timing, with an empty FIFO and an idle FSM: a handshake on edge k puts the
// code in the FIFO, the FSM pops it on edge k+1, and Data carries the word
// from edge k+1 through edge k+1+HOLD. With GAP>0 the word period is
// HOLD+GAP+1 because one idle cycle follows the gap before the next pop.
// -----------------------------------------------------------------------------
module decoder_pulse
    import decoder_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int GAP   = 1,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] Code,
    input  logic              Code_valid,
    output logic              Code_ready,
    output logic [DATA_W-1:0] Data,
    output logic              Busy,
    output logic              Done
);

    // Counter reload values. The counter counts down to zero, so a phase of
    // N cycles starts at N-1. GAP_LOAD is only used when GAP is non-zero.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);
    localparam bit         GAP_EN    = (GAP > 0);

    // ------------------------------------------------------------------
    // Code FIFO
    // ------------------------------------------------------------------
    logic                   fifo_push;
    logic                   fifo_pop;
    logic [CODE_W-1:0]      fifo_code;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign fifo_push = Code_valid && Code_ready;

    code_fifo #(
        .DEPTH (DEPTH)
    ) u_code_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_code (Code),
        .pop       (fifo_pop),
        .pop_code  (fifo_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready follows the registered fill level only; a pop in the same cycle
    // does not open a slot early.
    assign Code_ready = !fifo_full;

    // ------------------------------------------------------------------
    // Pulse FSM
    // ------------------------------------------------------------------
    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [7:0]        counter;
    logic [7:0]        counter_nx;
    logic [DATA_W-1:0] data_nx;
    logic              done_nx;

    // NOTE: every signal assigned in this block gets a default value first;
    // any path that left one of them unassigned would infer a latch.
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        data_nx    = Data;
        fifo_pop   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_nx    = onehot8(fifo_code);
                    counter_nx = HOLD_LOAD;
                    state_nx   = ST_DRIVE;
                end else begin
                    data_nx = '0;
                end
            end

            ST_DRIVE: begin
                if (counter != 8'd0) begin
                    counter_nx = counter - 1'b1;
                end else if (GAP_EN) begin
                    state_nx   = ST_GAP;
                    counter_nx = GAP_LOAD;
                    data_nx    = '0;
                end else if (!fifo_empty) begin
                    // Zero-gap chaining: the next word replaces the current
                    // one on the same edge, so Data never passes through zero.
                    fifo_pop   = 1'b1;
                    data_nx    = onehot8(fifo_code);
                    counter_nx = HOLD_LOAD;
                end else begin
                    state_nx = ST_IDLE;
                    data_nx  = '0;
                end
            end

            ST_GAP: begin
                data_nx = '0;
                if (counter != 8'd0) begin
                    counter_nx = counter - 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end

            default: begin
                state_nx   = ST_IDLE;
                counter_nx = 8'd0;
                data_nx    = '0;
            end
        endcase

        // Done is registered, so it is set on the edge that enters the final
        // drive cycle (counter reaching zero while in DRIVE). For HOLD=1 that
        // is the same edge that loads the word.
        done_nx = (state_nx == ST_DRIVE) && (counter_nx == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= 8'd0;
            Data    <= '0;
            Done    <= 1'b0;
        end else begin
            state   <= state_nx;
            counter <= counter_nx;
            Data    <= data_nx;
            Done    <= done_nx;
        end
    end

    assign Busy = (state != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_decoder_pulse.sv
// -----------------------------------------------------------------------------
// tb_decoder_pulse
//
// Two decoder_pulse instances share one clock: dut_a with HOLD=4, GAP=1 and
// dut_b with HOLD=4, GAP=0, both DEPTH=2. Codes are queued on a per-instance
// scoreboard when their handshake completes; a negedge monitor pops the
// scoreboard on every Done pulse and checks the word, its hold length, the
// zero gap (or the seamless reload when GAP=0), one-hot legality, and
// Code_ready against an occupancy model of the FIFO.
// -----------------------------------------------------------------------------
module tb_decoder_pulse;
    import decoder_pkg::*;

    localparam int HOLD  = 4;
    localparam int DEPTH = 2;
    localparam int GAP_A = 1;
    localparam int GAP_B = 0;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [2:0] code_a, code_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    decoder_pulse #(.HOLD(HOLD), .GAP(GAP_A), .DEPTH(DEPTH)) dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .Code       (code_a),
        .Code_valid (valid_a),
        .Code_ready (ready_a),
        .Data       (data_a),
        .Busy       (busy_a),
        .Done       (done_a)
    );

    decoder_pulse #(.HOLD(HOLD), .GAP(GAP_B), .DEPTH(DEPTH)) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .Code       (code_b),
        .Code_valid (valid_b),
        .Code_ready (ready_b),
        .Data       (data_b),
        .Busy       (busy_b),
        .Done       (done_b)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboards: codes accepted by each instance, oldest first.
    logic [2:0] sb_a[$];
    logic [2:0] sb_b[$];

    // Monitor state, indexed by instance (0 = dut_a, 1 = dut_b).
    int         hold_run  [2];
    int         zero_need [2];
    logic       exp_nx_vld[2];
    logic [7:0] exp_nx    [2];
    logic [7:0] prev_data [2];
    logic       prev_done [2];
    logic       will_xfer [2];
    int         occ       [2];
    int         done_cnt  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input int d);
        return (d == 0) ? sb_a.size() : sb_b.size();
    endfunction

    function automatic logic [2:0] sb_pop(input int d);
        return (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
    endfunction

    function automatic logic [2:0] sb_front(input int d);
        return (d == 0) ? sb_a[0] : sb_b[0];
    endfunction

    task automatic monitor(input int d, input logic r, input logic [7:0] dat,
                           input logic dn, input logic rdy, input logic vld,
                           input int gap);
        logic [2:0] e;
        if (r) begin
            hold_run[d]   = 0;
            zero_need[d]  = 0;
            exp_nx_vld[d] = 1'b0;
            prev_data[d]  = '0;
            prev_done[d]  = 1'b0;
            will_xfer[d]  = 1'b0;
            occ[d]        = 0;
            return;
        end
        // Occupancy model: a transfer seen last cycle landed on the edge just
        // passed; a pop shows up as a new word appearing after zero or Done.
        if (will_xfer[d]) occ[d]++;
        if ((prev_data[d] == 8'h00 || prev_done[d]) && dat != 8'h00) occ[d]--;
        check($sformatf("ready_vs_occupancy_%0d", d), rdy, occ[d] < DEPTH);
        check($sformatf("onehot0_%0d", d), $onehot0(dat), 1);
        if (zero_need[d] > 0) begin
            check($sformatf("gap_zero_%0d", d), dat, 8'h00);
            zero_need[d]--;
        end
        if (exp_nx_vld[d]) begin
            check($sformatf("b2b_next_word_%0d", d), dat, exp_nx[d]);
            exp_nx_vld[d] = 1'b0;
        end
        if (dat != 8'h00) hold_run[d]++;
        else              hold_run[d] = 0;
        if (dn) begin
            done_cnt[d]++;
            check($sformatf("done_has_expected_%0d", d), sb_size(d) != 0, 1);
            if (sb_size(d) != 0) begin
                e = sb_pop(d);
                check($sformatf("word_%0d", d), dat, onehot8(e));
                check($sformatf("hold_len_%0d", d), hold_run[d], HOLD);
            end
            hold_run[d] = 0;
            if (gap > 0) begin
                zero_need[d] = gap + 1;
            end else if (sb_size(d) != 0) begin
                exp_nx_vld[d] = 1'b1;
                exp_nx[d]     = onehot8(sb_front(d));
            end else begin
                zero_need[d] = 1;
            end
        end
        prev_data[d] = dat;
        prev_done[d] = dn;
        will_xfer[d] = vld && rdy;
    endtask

    always @(negedge clk) begin
        monitor(0, rst_a, data_a, done_a, ready_a, valid_a, GAP_A);
        monitor(1, rst_b, data_b, done_b, ready_b, valid_b, GAP_B);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one code and hold it until accepted; 'waited' counts cycles spent
    // with Code_ready low. Called and returns at posedge+1.
    task automatic send(input int d, input logic [2:0] c, output int waited);
        logic accepted;
        accepted = 1'b0;
        waited   = 0;
        if (d == 0) begin code_a = c; valid_a = 1'b1; end
        else        begin code_b = c; valid_b = 1'b1; end
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if ((d == 0) ? ready_a : ready_b) begin
                @(posedge clk);
                if (d == 0) sb_a.push_back(c);
                else        sb_b.push_back(c);
                accepted = 1'b1;
            end else begin
                waited++;
                @(posedge clk);
            end
        end
        #1;
        if (d == 0) valid_a = 1'b0;
        else        valid_b = 1'b0;
        check($sformatf("send_accepted_%0d", d), accepted, 1);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (((d == 0) ? busy_a : busy_b) && n < 100) begin
            tick(1);
            n++;
        end
        check($sformatf("reached_idle_%0d", d), (d == 0) ? busy_a : busy_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int base;

        rst_a   = 1'b1; rst_b   = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        code_a  = '0;   code_b  = '0;
        tick(3);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset values on both instances.
        @(negedge clk);
        check("rst_data_a",  data_a,  8'h00);
        check("rst_ready_a", ready_a, 1);
        check("rst_busy_a",  busy_a,  0);
        check("rst_done_a",  done_a,  0);
        check("rst_data_b",  data_b,  8'h00);
        check("rst_ready_b", ready_b, 1);
        check("rst_busy_b",  busy_b,  0);
        check("rst_done_b",  done_b,  0);
        @(posedge clk); #1;

        // Single code 5: one cycle of latency after the handshake edge.
        base = done_cnt[0];
        send(0, 3'd5, w);
        check("t1_data_after_handshake", data_a, 8'h00);
        check("t1_busy_queued", busy_a, 1);
        tick(1);
        check("t1_data_first_word", data_a, 8'h20);
        wait_idle(0);
        check("t1_data_idle", data_a, 8'h00);
        check("t1_done_count", done_cnt[0] - base, 1);

        // Continuous sweep 0..7 with GAP=1; FIFO fills and throttles ready.
        base = done_cnt[0];
        for (int c = 0; c < 8; c++) begin
            send(0, 3'(c), w);
        end
        wait_idle(0);
        check("t2_done_count", done_cnt[0] - base, 8);
        check("t2_sb_drained", sb_a.size(), 0);

        // GAP=0: 0 then 7 chained with no zero cycle; push and pop share an edge.
        base = done_cnt[1];
        send(1, 3'd0, w);
        send(1, 3'd7, w);
        check("t3_ready_count1", ready_b, 1);
        check("t3_first_word", data_b, 8'h01);
        wait_idle(1);
        check("t3_done_count", done_cnt[1] - base, 2);

        // Fill DEPTH=2 while a word drives; the fourth code must wait.
        base = done_cnt[0];
        send(0, 3'd6, w);
        send(0, 3'd4, w);
        send(0, 3'd2, w);
        check("t4_ready_low_full", ready_a, 0);
        send(0, 3'd1, w);
        check("t4_fourth_waited", w > 0, 1);
        wait_idle(0);
        check("t4_done_count", done_cnt[0] - base, 4);
        check("t4_sb_drained", sb_a.size(), 0);

        // Reset mid-DRIVE with two codes queued.
        send(0, 3'd3, w);
        send(0, 3'd1, w);
        send(0, 3'd2, w);
        check("t5_driving", data_a, 8'h08);
        rst_a = 1'b1;
        sb_a.delete();
        tick(1);
        rst_a = 1'b0;
        base = done_cnt[0];
        check("t5_data_zero",  data_a,  8'h00);
        check("t5_busy_low",   busy_a,  0);
        check("t5_ready_high", ready_a, 1);
        check("t5_no_done",    done_a,  0);
        tick(20);
        check("t5_nothing_emitted", done_cnt[0] - base, 0);
        check("t5_still_idle", busy_a, 0);

        // GAP=0 streaming sweep: repeated same-edge push/pop, pointer wrap.
        base = done_cnt[1];
        for (int c = 7; c >= 0; c--) begin
            send(1, 3'(c), w);
        end
        wait_idle(1);
        check("t6_done_count", done_cnt[1] - base, 8);
        check("t6_sb_drained", sb_b.size(), 0);

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_pulse.md
# decoder_pulse

Sequential 3-to-8 one-hot decoder that drives the 8-bit `Data` bus from queued 3-bit `Code` words. It is the counterpart of the team's 8-to-3 priority encoder, which takes `Data` and produces `Code`. Codes arrive over a valid/ready handshake and are buffered in a small FIFO. Each code is replayed as a one-hot pulse of fixed width followed by a fixed idle gap, so `Data` can drive the encoder input or any one-hot-select consumer.

## Interface
- `HOLD`, 4: cycles each one-hot word is driven; legal range 1..255.
- `GAP`, 1: cycles `Data` is forced to zero between words; legal range 0..255. 0 means back-to-back words.
- `DEPTH`, 2: FIFO entries; power of 2, range 2..16.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Code` input 3: binary index to decode; bit `Code` of `Data` is set.
- `Code_valid` input 1: `Code` is valid this cycle.
- `Code_ready` output 1: FIFO can accept; a transfer happens when valid and ready are both high.
- `Data` output 8: registered one-hot word, or 8'h00 when not driving.
- `Busy` output 1: high when FSM is not in IDLE or the FIFO is non-empty.
- `Done` output 1: one-cycle pulse during the last DRIVE cycle of each word.

## Operation
- Reset values: `Data`=8'h00, `Code_ready`=1, `Busy`=0, `Done`=0; FIFO empty; FSM in IDLE; counter 0.
- `Code_ready` = !fifo_full, registered-count based. A pop in the same cycle does not raise ready while full (no bypass).
- `Code_valid` while `Code_ready`=0: ignored. Source must hold `Code`.
- All 8 codes are legal. There is no error path.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load `Data`=1<<code, counter=HOLD-1, go DRIVE. Else `Data`=0.
  - DRIVE: `Data` held.
    - counter>0: decrement.
    - counter==0: `Done`=1. If GAP>0, go GAP with counter=GAP-1 and `Data`=0 at the next edge. If GAP==0 and FIFO non-empty, pop and reload DRIVE directly (no zero cycle). Else go IDLE.
  - GAP: `Data`=0. Decrement; at 0, go IDLE.
- Push and pop in the same cycle: both take effect and the count is unchanged. A push into an empty FIFO is not visible to the FSM until the next cycle.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. Counter is 8 bits.
- `rst` mid-pulse: the next edge forces all reset values, discards FIFO contents, and emits no `Done`.

## Timing
- Empty FIFO, IDLE, handshake at edge k: `Data` one-hot from after edge k+1 through edge k+1+HOLD (HOLD cycles). `Done` is high in the final one of those cycles.
- GAP>0: `Data`=0 for exactly GAP cycles, then ≥1 IDLE cycle before the next word. Word period is HOLD+GAP+1.
- GAP==0 with FIFO non-empty: word period is exactly HOLD and `Data` never returns to 0 between words.
- Sustained throughput is bounded by the pulse period, so the FIFO fills and `Code_ready` deasserts.
- All outputs are registered except `Code_ready` and `Busy`, which are decoded from registered state.

## Structure
- Shared package `decoder_pkg`: FSM state encoding (IDLE=2'd0, DRIVE=2'd1, GAP=2'd2) and a `onehot8(code)` function.
- Sub-module `code_fifo`: synchronous FIFO, width 3, parameter DEPTH, with push/pop/full/empty/count.
- Top level holds the FSM, the counter, and the `Data` register.

## Test plan
- Reset, then accept Code=3'd5 (HOLD=4, GAP=1): `Data`=8'h20 for 4 cycles starting the cycle after the edge following the handshake; 1 `Done` pulse; `Data`=0 for 1 GAP cycle; `Busy` drops after return to IDLE.
- Sweep Codes 0..7 continuously: `Data` sequence 8'h01,02,04,...,80, each held HOLD cycles. `Code_ready` low whenever the FIFO holds DEPTH entries and no transfer occurs then.
- GAP=0, push 3'd0 then 3'd7: 8'h01 for HOLD cycles, immediately 8'h80 for HOLD cycles, no 8'h00 cycle between; 2 `Done` pulses.
- Fill FIFO (DEPTH=2) while a word drives, keep `Code_valid` high with a third code: third code not accepted until a pop. Words emerge in order, no loss or duplication.
- Assert `rst` for 1 cycle mid-DRIVE with 2 queued codes: next cycle `Data`=0, `Busy`=0, `Code_ready`=1, no `Done`. Queued codes are never emitted.
- Push and pop on the same edge with count=1: count stays 1, pointer wrap verified over ≥3×DEPTH transfers.
